switch_reader: RTL and testbench

Input-side companion to the board LED logic: samples the raw DIP-switch pins, synchronizes them into the clock domain, debounces each bit independently, and presents a clean 4-bit switch vector `s`. It also generates the free-running 16-bit `counter` consumed by the LED blink logic. It sits between the package pins and the LED/display control blocks.

---
 rtl/switch_reader.sv | 121 ++++++++++++
 tb/tb_switch_reader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/switch_reader.sv
// switch_reader: brings raw DIP-switch pins into the clock domain through a
// two-flop synchronizer, debounces every bit with its own small FSM, flags
// the cycle in which the clean vector changes, and provides the free-running
// tick counter used by the LED blink logic.
module switch_reader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int PERIOD          = 65536
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] s,
  output logic             s_changed,
  output logic [15:0]      counter
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);
  // PERIOD = 65536 truncates to 16'hFFFF, so the explicit wrap coincides
  // with natural 16-bit rollover.
  localparam logic [15:0] CNT_LAST = 16'(PERIOD - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  logic [WIDTH-1:0]  r_sync1;
  logic [WIDTH-1:0]  r_sync2;
  logic [WIDTH-1:0]  r_s;
  logic              r_s_changed;
  logic [15:0]       r_counter;
  state_t            r_state [WIDTH];
  logic [DCNT_W-1:0] r_dcnt  [WIDTH];
  logic [WIDTH-1:0]  w_commit;

  assign s         = r_s;
  assign s_changed = r_s_changed;
  assign counter   = r_counter;

  // Two-flop synchronizer; nothing else looks at sw_raw.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A bit commits on the edge where it has already seen DEBOUNCE_CYCLES
  // differing samples and the current sample still differs.
  always_comb begin
    w_commit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_commit[i] = (r_state[i] == ST_SETTLING) &&
                    (r_sync2[i] != r_s[i]) &&
                    (r_dcnt[i] == DCNT_MAX);
    end
  end

  // Per-bit debounce FSMs with the committed vector and its change pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s         <= '0;
      r_s_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= ST_STABLE;
        r_dcnt[i]  <= '0;
      end
    end else begin
      // Any number of simultaneous commits still produces a single pulse,
      // aligned with the cycle in which the new s is visible.
      r_s_changed <= |w_commit;
      for (int i = 0; i < WIDTH; i++) begin
        case (r_state[i])
          ST_STABLE: begin
            if (r_sync2[i] != r_s[i]) begin
              r_state[i] <= ST_SETTLING;
              r_dcnt[i]  <= DCNT_ONE;
            end else begin
              r_dcnt[i]  <= '0;
            end
          end
          ST_SETTLING: begin
            if (r_sync2[i] == r_s[i]) begin
              // Bounced back: drop all progress, the window restarts.
              r_state[i] <= ST_STABLE;
              r_dcnt[i]  <= '0;
            end else if (w_commit[i]) begin
              r_s[i]     <= r_sync2[i];
              r_state[i] <= ST_STABLE;
              r_dcnt[i]  <= '0;
            end else begin
              r_dcnt[i]  <= r_dcnt[i] + DCNT_ONE;
            end
          end
          default: begin
            r_state[i] <= ST_STABLE;
            r_dcnt[i]  <= '0;
          end
        endcase
      end
    end
  end

  // Free-running tick counter, wraps after PERIOD-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_counter <= '0;
    end else if (r_counter == CNT_LAST) begin
      r_counter <= '0;
    end else begin
      r_counter <= r_counter + 16'd1;
    end
  end

endmodule

// File: tb/tb_switch_reader.sv
// Directed bench for switch_reader: a fast instance (DEBOUNCE_CYCLES=8,
// PERIOD=16) for the switch scenarios and a default-sized instance for the
// long debounce window and 16-bit counter rollover.
module tb_switch_reader;

  logic        clk;
  logic        rst_a;
  logic        rst_b;
  logic [3:0]  sw_a;
  logic [3:0]  sw_b;
  logic [3:0]  s_a;
  logic [3:0]  s_b;
  logic        sc_a;
  logic        sc_b;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;

  int n_tests;
  int n_fail;
  int pulses_a;
  int pulses_b;
  int n_b;

  switch_reader #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .PERIOD(16)) u_dut_a (
    .clk       (clk),
    .reset     (rst_a),
    .sw_raw    (sw_a),
    .s         (s_a),
    .s_changed (sc_a),
    .counter   (cnt_a)
  );

  switch_reader #(.WIDTH(4), .DEBOUNCE_CYCLES(20000), .PERIOD(65536)) u_dut_b (
    .clk       (clk),
    .reset     (rst_b),
    .sw_raw    (sw_b),
    .s         (s_b),
    .s_changed (sc_b),
    .counter   (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference edge count for instance b since its reset release.
  always @(posedge clk) begin
    if (rst_b) n_b <= n_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each, and tally pulses.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (sc_a === 1'b1) pulses_a++;
      if (sc_b === 1'b1) pulses_b++;
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    pulses_a = 0;
    pulses_b = 0;
    n_b      = 0;
    rst_a    = 1'b0;
    rst_b    = 1'b0;
    sw_a     = 4'b0000;
    sw_b     = 4'b0000;

    #23;
    chk("por_s", 32'(s_a), 32'd0);
    chk("por_cnt", 32'(cnt_a), 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Establish a non-zero committed state, then reset mid-settle.
    @(posedge clk); #1;
    sw_a = 4'b0011;
    step(15);
    chk("pre_s", 32'(s_a), 32'd3);
    sw_a = 4'b1111;
    step(5);
    #3;
    rst_a = 1'b0;
    #1;
    chk("rst_s", 32'(s_a), 32'd0);
    chk("rst_sc", 32'(sc_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_s", 32'(s_a), 32'd0);
    rst_a = 1'b1;

    // Switches on through reset: commit via normal path; counter 1..15,0,1.
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      chk("cnt_seq", 32'(cnt_a), 32'(k % 16));
      if (k == 10) chk("rel_s_early", 32'(s_a), 32'd0);
      if (k == 11) begin
        chk("rel_s", 32'(s_a), 32'hF);
        chk("rel_sc", 32'(sc_a), 32'd1);
      end
      if (k == 12) chk("rel_sc_off", 32'(sc_a), 32'd0);
    end

    // Clean press on bit 0.
    sw_a = 4'b0000;
    step(15);
    chk("clr_s", 32'(s_a), 32'd0);
    sw_a = 4'b0001;
    step(10);
    chk("press_early", 32'(s_a), 32'd0);
    step(1);
    chk("press_s", 32'(s_a), 32'd1);
    chk("press_sc", 32'(sc_a), 32'd1);
    step(1);
    chk("press_sc_off", 32'(sc_a), 32'd0);
    chk("press_hold", 32'(s_a), 32'd1);

    // Bounce on bit 1, then hold high.
    pulses_a = 0;
    sw_a = 4'b0011; step(3);
    sw_a = 4'b0001; step(3);
    sw_a = 4'b0011; step(3);
    sw_a = 4'b0001; step(3);
    sw_a = 4'b0011; step(10);
    chk("bounce_pulses", 32'(pulses_a), 32'd0);
    chk("bounce_s", 32'(s_a), 32'd1);
    step(1);
    chk("bounce_commit", 32'(s_a), 32'd3);
    chk("bounce_sc", 32'(sc_a), 32'd1);

    // Short glitch on bit 2.
    pulses_a = 0;
    sw_a = 4'b0111; step(5);
    sw_a = 4'b0011; step(20);
    chk("glitch_pulses", 32'(pulses_a), 32'd0);
    chk("glitch_s", 32'(s_a), 32'd3);

    // Simultaneous commit of bits 3 and 2.
    sw_a = 4'b0000;
    step(15);
    chk("sim_clr", 32'(s_a), 32'd0);
    pulses_a = 0;
    sw_a = 4'b1100;
    step(10);
    chk("sim_early", 32'(s_a), 32'd0);
    step(1);
    chk("sim_s", 32'(s_a), 32'hC);
    chk("sim_sc", 32'(sc_a), 32'd1);
    step(1);
    chk("sim_sc_off", 32'(sc_a), 32'd0);
    step(15);
    chk("sim_pulses", 32'(pulses_a), 32'd1);

    // Long window: 20000 stable samples do not commit, 20001 do.
    pulses_b = 0;
    sw_b = 4'b0001;
    step(20000);
    sw_b = 4'b0000;
    step(30);
    chk("long_short_s", 32'(s_b), 32'd0);
    chk("long_short_pulses", 32'(pulses_b), 32'd0);
    sw_b = 4'b0010;
    step(20001);
    sw_b = 4'b0000;
    step(3);
    chk("long_commit_s", 32'(s_b), 32'd2);
    chk("long_commit_pulses", 32'(pulses_b), 32'd1);
    chk("b_cnt_mid", 32'(cnt_b), 32'(n_b % 65536));

    // 16-bit rollover on the default-period instance.
    while (n_b < 65535) step(1);
    chk("b_cnt_max", 32'(cnt_b), 32'd65535);
    step(1);
    chk("b_cnt_wrap", 32'(cnt_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
